// File: rtl/regfile_wb_bypass.sv
// regfile_wb_bypass: decode-stage register file with a one-entry write-back register and read bypass
module regfile_wb_bypass #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit INIT_INDEX = 1,
  parameter int LINK_REG   = 31,
  parameter int LINK_W     = 16,
  parameter bit BYPASS     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [31:0]       opcplus4,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              Jal,
  input  logic              MemtoReg,
  input  logic              stall,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [31:0]       Sign_extend,
  output logic              wb_pending,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] rs, rt, rd, dest;
  logic [DATA_W-1:0] wr_data;
  logic [5:0]        opcode;
  logic [15:0]       imm;
  logic              unused_ok;
  assign opcode    = Instruction[31:26];
  assign rs        = Instruction[21 +: ADDR_W];
  assign rt        = Instruction[16 +: ADDR_W];
  assign rd        = Instruction[11 +: ADDR_W];
  assign imm       = Instruction[15:0];
  assign unused_ok = ^{opcplus4, Instruction};
  always_comb begin
    dest        = Jal ? ADDR_W'(LINK_REG) : RegDst ? rd : rt;
    wr_data     = Jal ? DATA_W'(opcplus4[LINK_W-1:0]) : MemtoReg ? read_data : ALU_result;
    wb_we_d     = stall ? 1'b0 : RegWrite && (dest != '0);
    wb_addr_d   = stall ? wb_addr_q : dest;
    wb_data_d   = stall ? wb_data_q : wr_data;
    Sign_extend = (opcode >= 6'h0B && opcode <= 6'h0E) ? {16'h0, imm} : {{16{imm[15]}}, imm};
  end
  // A stalled cycle loads a bubble; the previous entry still commits on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= INIT_INDEX ? DATA_W'(i) : '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (wb_we_q && wb_addr_q != '0) regs_q[wb_addr_q] <= wb_data_q;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end
  always_comb begin
    read_data_1 = (rs == '0) ? '0 : (BYPASS && wb_we_q && wb_addr_q == rs) ? wb_data_q : regs_q[rs];
    read_data_2 = (rt == '0) ? '0 : (BYPASS && wb_we_q && wb_addr_q == rt) ? wb_data_q : regs_q[rt];
    dbg_data    = regs_q[dbg_addr];
  end
  assign wb_pending = wb_we_q;
endmodule

// File: tb/tb_regfile_wb_bypass.sv
// tb_regfile_wb_bypass: randomized and directed checks of regfile_wb_bypass against a write-queue model
module tb_regfile_wb_bypass;
  logic        clock = 0, reset = 0;
  logic [31:0] Instruction = 0, ALU_result = 0, read_data = 0, opcplus4 = 0;
  logic        RegWrite = 0, RegDst = 0, Jal = 0, MemtoReg = 0, stall = 0;
  logic [31:0] read_data_1, read_data_2, Sign_extend, dbg_data;
  logic        wb_pending;
  logic [4:0]  dbg_addr = 0;
  int          checks = 0, passed = 0;
  logic [31:0] m [32];
  logic [31:0] pq_data [$];
  logic [4:0]  pq_addr [$];

  regfile_wb_bypass dut (
    .clock(clock), .reset(reset), .Instruction(Instruction), .ALU_result(ALU_result),
    .read_data(read_data), .opcplus4(opcplus4), .RegWrite(RegWrite), .RegDst(RegDst),
    .Jal(Jal), .MemtoReg(MemtoReg), .stall(stall), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .Sign_extend(Sign_extend), .wb_pending(wb_pending),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 0;
    if (pq_addr.size() != 0 && pq_addr[0] == idx) return pq_data[0];
    return m[idx];
  endfunction

  function automatic logic [31:0] exp_sx(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op >= 11 && op <= 14) return {16'h0, ins[15:0]};
    return 32'($signed(ins[15:0]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = i;
    pq_addr.delete();
    pq_data.delete();
  endtask

  task automatic clear_ctl();
    RegWrite = 0; RegDst = 0; Jal = 0; MemtoReg = 0; stall = 0;
  endtask

  task automatic tick();
    logic [4:0]  d;
    logic [31:0] v;
    @(posedge clock);
    d = Jal ? 5'd31 : RegDst ? Instruction[15:11] : Instruction[20:16];
    v = Jal ? {16'h0, opcplus4[15:0]} : MemtoReg ? read_data : ALU_result;
    if (pq_addr.size() != 0) begin
      m[pq_addr.pop_front()] = pq_data.pop_front();
    end
    if (!stall && RegWrite && d != 0) begin
      pq_addr.push_back(d);
      pq_data.push_back(v);
    end
    #1;
  endtask

  task automatic test_reset();
    Instruction = mk(6'h00, 5'd5, 5'd31, 16'h0);
    dbg_addr = 17;
    #1;
    checks++; if (read_data_1 !== 32'd5) $display("FAIL reset_rs5 got %h want %h", read_data_1, 32'd5); else passed++;
    checks++; if (read_data_2 !== 32'd31) $display("FAIL reset_rt31 got %h want %h", read_data_2, 32'd31); else passed++;
    checks++; if (wb_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", wb_pending); else passed++;
    checks++; if (dbg_data !== 32'd17) $display("FAIL reset_dbg17 got %h want %h", dbg_data, 32'd17); else passed++;
    Instruction = mk(6'h00, 5'd0, 5'd0, 16'h0);
    dbg_addr = 0;
    #1;
    checks++; if (read_data_1 !== 32'd0) $display("FAIL reset_r0 got %h want 0", read_data_1); else passed++;
    checks++; if (dbg_data !== 32'd0) $display("FAIL reset_dbg0 got %h want 0", dbg_data); else passed++;
  endtask

  task automatic test_rtype_bypass();
    clear_ctl();
    Instruction = mk(6'h00, 5'd1, 5'd2, {5'd8, 11'h0});
    RegWrite = 1; RegDst = 1; ALU_result = 32'hDEADBEEF;
    tick();
    checks++; if (wb_pending !== 1'b1) $display("FAIL rtype_pending got %b want 1", wb_pending); else passed++;
    clear_ctl();
    Instruction = mk(6'h00, 5'd8, 5'd8, 16'h0);
    dbg_addr = 8;
    #1;
    checks++; if (read_data_1 !== 32'hDEADBEEF) $display("FAIL rtype_bypass_rs got %h want DEADBEEF", read_data_1); else passed++;
    checks++; if (read_data_2 !== 32'hDEADBEEF) $display("FAIL rtype_bypass_rt got %h want DEADBEEF", read_data_2); else passed++;
    checks++; if (dbg_data !== 32'd8) $display("FAIL rtype_dbg_stale got %h want 8", dbg_data); else passed++;
    tick();
    checks++; if (dbg_data !== 32'hDEADBEEF) $display("FAIL rtype_commit got %h want DEADBEEF", dbg_data); else passed++;
  endtask

  task automatic test_jal();
    clear_ctl();
    Instruction = mk(6'h03, 5'd0, 5'd0, {5'd7, 11'h0});
    Jal = 1; RegDst = 1; RegWrite = 1; opcplus4 = 32'h00401234; ALU_result = 32'hFFFF0000;
    tick();
    clear_ctl();
    tick();
    dbg_addr = 31; #1;
    checks++; if (dbg_data !== 32'h00001234) $display("FAIL jal_link got %h want 00001234", dbg_data); else passed++;
    dbg_addr = 7; #1;
    checks++; if (dbg_data !== 32'd7) $display("FAIL jal_rd_untouched got %h want 7", dbg_data); else passed++;
  endtask

  task automatic test_stall_load();
    clear_ctl();
    Instruction = mk(6'h23, 5'd1, 5'd4, 16'h0);
    RegWrite = 1; MemtoReg = 1; read_data = 32'h5A5A5A5A; stall = 1; dbg_addr = 4;
    tick();
    checks++; if (wb_pending !== 1'b0) $display("FAIL stall_pending got %b want 0", wb_pending); else passed++;
    checks++; if (dbg_data !== 32'd4) $display("FAIL stall_nowrite got %h want 4", dbg_data); else passed++;
    stall = 0;
    tick();
    checks++; if (wb_pending !== 1'b1) $display("FAIL load_pending got %b want 1", wb_pending); else passed++;
    clear_ctl();
    tick();
    checks++; if (dbg_data !== 32'h5A5A5A5A) $display("FAIL load_commit got %h want 5A5A5A5A", dbg_data); else passed++;
  endtask

  task automatic test_r0();
    clear_ctl();
    Instruction = mk(6'h00, 5'd0, 5'd0, {5'd0, 11'h0});
    RegWrite = 1; RegDst = 1; ALU_result = 32'hFFFFFFFF;
    tick();
    checks++; if (wb_pending !== 1'b0) $display("FAIL r0_pending got %b want 0", wb_pending); else passed++;
    clear_ctl();
    tick();
    checks++; if (read_data_1 !== 32'd0) $display("FAIL r0_read got %h want 0", read_data_1); else passed++;
  endtask

  task automatic test_sign_extend();
    Instruction = mk(6'h0D, 5'd0, 5'd0, 16'h8000); #1;
    checks++; if (Sign_extend !== 32'h00008000) $display("FAIL sx_zero got %h want 00008000", Sign_extend); else passed++;
    Instruction = mk(6'h08, 5'd0, 5'd0, 16'h8000); #1;
    checks++; if (Sign_extend !== 32'hFFFF8000) $display("FAIL sx_sign got %h want FFFF8000", Sign_extend); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      Instruction = $urandom;
      ALU_result = $urandom; read_data = $urandom; opcplus4 = $urandom;
      RegWrite = ($urandom_range(0, 3) != 0);
      RegDst = $urandom_range(0, 1); MemtoReg = $urandom_range(0, 1);
      Jal = ($urandom_range(0, 7) == 0); stall = ($urandom_range(0, 5) == 0);
      if (n % 4 == 0) Instruction[25:21] = Instruction[20:16];
      dbg_addr = 5'($urandom);
      #1;
      checks++; if (read_data_1 !== exp_rd(Instruction[25:21])) $display("FAIL rnd_rs n=%0d got %h want %h", n, read_data_1, exp_rd(Instruction[25:21])); else passed++;
      checks++; if (read_data_2 !== exp_rd(Instruction[20:16])) $display("FAIL rnd_rt n=%0d got %h want %h", n, read_data_2, exp_rd(Instruction[20:16])); else passed++;
      checks++; if (dbg_data !== m[dbg_addr]) $display("FAIL rnd_dbg n=%0d got %h want %h", n, dbg_data, m[dbg_addr]); else passed++;
      checks++; if (wb_pending !== (pq_addr.size() != 0)) $display("FAIL rnd_pending n=%0d got %b want %b", n, wb_pending, pq_addr.size() != 0); else passed++;
      checks++; if (Sign_extend !== exp_sx(Instruction)) $display("FAIL rnd_sx n=%0d got %h want %h", n, Sign_extend, exp_sx(Instruction)); else passed++;
      tick();
    end
    clear_ctl();
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_data !== m[i]) $display("FAIL rnd_final r%0d got %h want %h", i, dbg_data, m[i]); else passed++;
    end
  endtask

  task automatic test_async_reset();
    clear_ctl();
    Instruction = mk(6'h00, 5'd0, 5'd0, {5'd9, 11'h0});
    RegWrite = 1; RegDst = 1; ALU_result = 32'hCAFEF00D;
    tick();
    clear_ctl();
    Instruction = mk(6'h00, 5'd9, 5'd0, 16'h0);
    dbg_addr = 9;
    #1;
    checks++; if (wb_pending !== 1'b1) $display("FAIL arst_pre_pending got %b want 1", wb_pending); else passed++;
    #1 reset = 0;
    model_reset();
    #1;
    checks++; if (wb_pending !== 1'b0) $display("FAIL arst_pending got %b want 0", wb_pending); else passed++;
    checks++; if (read_data_1 !== 32'd9) $display("FAIL arst_read got %h want 9", read_data_1); else passed++;
    #1 reset = 1;
    tick();
    tick();
    checks++; if (dbg_data !== 32'd9) $display("FAIL arst_lost got %h want 9", dbg_data); else passed++;
  endtask

  initial begin
    model_reset();
    #12 reset = 1;
    test_reset();
    test_rtype_bypass();
    test_jal();
    test_stall_load();
    test_r0();
    test_sign_extend();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
